// File: rtl/nx_instr_pkg.sv
// Shared width helpers and address type for the multi-core instruction store.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   cw_f / aw_f / pw_f : core-index, local-address and populated-count widths
//   instr_addr_t       : {core index, region-local address}, sized for up to 8 cores / 64K entries
//   phys_addr_f        : flattens an instr_addr_t into a physical RAM index
package nx_instr_pkg;

  function automatic int cw_f(input int cores);
    return (cores > 1) ? $clog2(cores) : 1;
  endfunction

  function automatic int aw_f(input int max_instrs, input int cores);
    return $clog2(max_instrs / cores);
  endfunction

  function automatic int pw_f(input int max_instrs, input int cores);
    return aw_f(max_instrs, cores) + 1;
  endfunction

  typedef struct packed {
    logic [2:0]  core_idx;
    logic [15:0] local_addr;
  } instr_addr_t;

  // Core index sits directly above the local address. With a single core the
  // index is always 0, so the result degenerates to the local address alone.
  function automatic logic [31:0] phys_addr_f(input instr_addr_t a, input int aw);
    return (32'(a.core_idx) << aw) | 32'(a.local_addr);
  endfunction

endpackage

// File: rtl/nx_rr_arbiter.sv
// Round-robin arbiter: one-hot grant over req_i, search starts at the registered pointer.
// Latency: grant is combinational; pointer moves to winner+1 on the clock after a grant.
// Backpressure: en_i low suppresses all grants and freezes the pointer.
//
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (pointer -> 0)
//   req_i [N]    : request vector
//   en_i         : grant enable
//   gnt_o [N]    : one-hot grant (all zero when nothing granted)
//   ptr_o        : registered round-robin pointer
module nx_rr_arbiter
  import nx_instr_pkg::*;
#(
  parameter int N = 2,
  localparam int PTRW = cw_f(N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic            en_i,
  output logic [N-1:0]    gnt_o,
  output logic [PTRW-1:0] ptr_o
);

  logic [PTRW-1:0] r_ptr;
  logic [PTRW-1:0] w_ptr_nxt;
  logic            w_found;
  int              w_idx;

  always_comb begin
    gnt_o     = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    w_idx     = 0;
    if (en_i) begin
      for (int i = 0; i < N; i++) begin
        w_idx = (int'(r_ptr) + i) % N;
        if (!w_found && req_i[w_idx]) begin
          w_found      = 1'b1;
          gnt_o[w_idx] = 1'b1;
          w_ptr_nxt    = PTRW'((w_idx + 1) % N);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign ptr_o = r_ptr;

endmodule

// File: rtl/nx_instr_store_multi.sv
// Shared instruction store: appends decoder loads per core region, serves core fetches round-robin from one single-port RAM.
// Latency: load -> populated_o 1 cycle; fetch grant in cycle N -> core_data_o in cycle N+1.
// Backpressure: loads never stall; a load owns the RAM port and stalls every fetch that cycle; losing fetchers stall.
//
// Ports:
//   clk_i, rst_i                : clock, synchronous active-high reset
//   store_core_i/_data_i/_valid_i : instruction load (append to the target core's region)
//   populated_o  [CORES x PW]   : per-core loaded count
//   overflow_o   [CORES]        : sticky, a load was dropped on a full region
//   core_addr_i  [CORES x AW]   : per-core region-relative fetch address
//   core_rd_i    [CORES]        : per-core fetch request (held while stalled)
//   core_data_o  [CORES x IW]   : per-core fetched instruction, held between grants
//   core_stall_o [CORES]        : request not serviced this cycle
//   parity_err_o [CORES]        : sticky stored-parity mismatch
// Optional feature macro: NX_INSTR_PARITY_EN (adds an even-parity bit per RAM word).
module nx_instr_store_multi
  import nx_instr_pkg::*;
#(
  parameter int INSTR_WIDTH = 15,
  parameter int MAX_INSTRS  = 512,
  parameter int CORES       = 2,
  localparam int CW = cw_f(CORES),
  localparam int AW = aw_f(MAX_INSTRS, CORES),
  localparam int PW = pw_f(MAX_INSTRS, CORES)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [CW-1:0]                store_core_i,
  input  logic [INSTR_WIDTH-1:0]       store_data_i,
  input  logic                         store_valid_i,
  output logic [CORES*PW-1:0]          populated_o,
  output logic [CORES-1:0]             overflow_o,
  input  logic [CORES*AW-1:0]          core_addr_i,
  input  logic [CORES-1:0]             core_rd_i,
  output logic [CORES*INSTR_WIDTH-1:0] core_data_o,
  output logic [CORES-1:0]             core_stall_o,
  output logic [CORES-1:0]             parity_err_o
);

  localparam int REGION = MAX_INSTRS / CORES;
  localparam int RAW    = $clog2(MAX_INSTRS);
`ifdef NX_INSTR_PARITY_EN
  localparam int RW = INSTR_WIDTH + 1;
`else
  localparam int RW = INSTR_WIDTH;
`endif

  logic [RW-1:0]          r_mem [MAX_INSTRS];
  logic [RW-1:0]          r_rdata;
  logic                   r_rd_vld;
  logic [CW-1:0]          r_rd_core;
  logic [INSTR_WIDTH-1:0] r_hold [CORES];
  logic [PW-1:0]          r_pop [CORES];
  logic [CORES-1:0]       r_ovf;

  logic [CORES-1:0]       w_gnt;
  logic [CW-1:0]          w_unused_rr_ptr;
  logic                   w_arb_en;
  logic [CW-1:0]          w_win;
  logic [AW-1:0]          w_rd_local;
  instr_addr_t            w_rd_addr;
  instr_addr_t            w_wr_addr;
  logic [RAW-1:0]         w_rd_phys;
  logic [RAW-1:0]         w_wr_phys;
  logic                   w_st_full;
  logic                   w_wr_en;
  logic [RW-1:0]          w_wr_data;
  logic [INSTR_WIDTH-1:0] w_rd_data;

  // Loads (and reset) take the RAM port, so fetch arbitration is simply disabled.
  assign w_arb_en = ~store_valid_i & ~rst_i;

  nx_rr_arbiter #(.N(CORES)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (core_rd_i),
    .en_i  (w_arb_en),
    .gnt_o (w_gnt),
    .ptr_o (w_unused_rr_ptr)
  );

  // With the arbiter disabled w_gnt is zero, so this also covers the
  // load-priority and in-reset cases: every requester stalls.
  assign core_stall_o = core_rd_i & ~w_gnt;

  always_comb begin
    w_win      = '0;
    w_rd_local = '0;
    for (int c = 0; c < CORES; c++) begin
      if (w_gnt[c]) begin
        w_win      = CW'(c);
        w_rd_local = core_addr_i[c*AW +: AW];
      end
    end
  end

  assign w_rd_addr = '{core_idx: 3'(w_win), local_addr: 16'(w_rd_local)};
  assign w_rd_phys = RAW'(phys_addr_f(w_rd_addr, AW));

  assign w_st_full = (r_pop[store_core_i] == PW'(REGION));
  assign w_wr_en   = store_valid_i & ~rst_i & ~w_st_full;
  assign w_wr_addr = '{core_idx: 3'(store_core_i), local_addr: 16'(r_pop[store_core_i][AW-1:0])};
  assign w_wr_phys = RAW'(phys_addr_f(w_wr_addr, AW));

`ifdef NX_INSTR_PARITY_EN
  assign w_wr_data = {^store_data_i, store_data_i};
`else
  assign w_wr_data = store_data_i;
`endif

  // Single-port RAM: write and read never coincide since a load blocks all grants.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[w_wr_phys] <= w_wr_data;
    end else if (|w_gnt) begin
      r_rdata <= r_mem[w_rd_phys];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_vld  <= 1'b0;
      r_rd_core <= '0;
      r_ovf     <= '0;
      for (int c = 0; c < CORES; c++) begin
        r_pop[c]  <= '0;
        r_hold[c] <= '0;
      end
    end else begin
      if (store_valid_i) begin
        if (w_st_full) r_ovf[store_core_i] <= 1'b1;
        else           r_pop[store_core_i] <= r_pop[store_core_i] + PW'(1);
      end
      r_rd_vld <= |w_gnt;
      if (|w_gnt) r_rd_core <= w_win;
      // Capture the just-delivered word so it persists until that core's next grant.
      if (r_rd_vld) r_hold[r_rd_core] <= w_rd_data;
    end
  end

  assign w_rd_data = r_rdata[INSTR_WIDTH-1:0];

  // The RAM output register drives the granted core directly in the cycle after
  // its grant; other cores see their held word.
  always_comb begin
    core_data_o = '0;
    populated_o = '0;
    for (int c = 0; c < CORES; c++) begin
      core_data_o[c*INSTR_WIDTH +: INSTR_WIDTH] =
        (r_rd_vld && (r_rd_core == CW'(c))) ? w_rd_data : r_hold[c];
      populated_o[c*PW +: PW] = r_pop[c];
    end
  end

  assign overflow_o = r_ovf;

`ifdef NX_INSTR_PARITY_EN
  logic [CORES-1:0] r_perr;
  logic [CORES-1:0] w_perr_now;

  // Even parity over {parity, data}: any odd word is corrupt. Flag it in the
  // same cycle the data appears, then keep it sticky.
  always_comb begin
    w_perr_now = '0;
    for (int c = 0; c < CORES; c++) begin
      w_perr_now[c] = r_rd_vld && (r_rd_core == CW'(c)) && (^r_rdata);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_perr <= '0;
    else       r_perr <= r_perr | w_perr_now;
  end

  assign parity_err_o = r_perr | w_perr_now;
`else
  assign parity_err_o = '0;
`endif

endmodule

// File: tb/tb_nx_instr_store_multi.sv
module tb_nx_instr_store_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  st_core;
  logic [14:0] st_data;
  logic        st_vld;
  logic [17:0] pop_o;
  logic [1:0]  ovf_o;
  logic [15:0] addr_i;
  logic [1:0]  rd_i;
  logic [29:0] data_o;
  logic [1:0]  stall_o;
  logic [1:0]  perr_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-core regions as plain arrays, counts, sticky flags,
  // and the round-robin rule "first requester at or after the pointer".
  logic [14:0] m_mem [512];
  bit          m_known [512];
  int          m_pop [2];
  bit [1:0]    m_ovf;
  int          m_rr;
  logic [14:0] m_data [2];
  bit          m_data_known [2];
  logic [1:0]  e_stall;
  int          e_win;

  nx_instr_store_multi dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .store_core_i  (st_core),
    .store_data_i  (st_data),
    .store_valid_i (st_vld),
    .populated_o   (pop_o),
    .overflow_o    (ovf_o),
    .core_addr_i   (addr_i),
    .core_rd_i     (rd_i),
    .core_data_o   (data_o),
    .core_stall_o  (stall_o),
    .parity_err_o  (perr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Predict this cycle's stalls from the currently driven inputs; sample at negedge.
  task automatic eval();
    @(negedge clk);
    e_win = -1;
    e_stall = rd_i;
    if (!rst && !st_vld) begin
      for (int k = 0; k < 2; k++) begin
        int c = (m_rr + k) % 2;
        if (rd_i[c] && e_win < 0) e_win = c;
      end
      if (e_win >= 0) e_stall[e_win] = 1'b0;
    end
  endtask

  // Apply the clock edge to the model, then move past it for the next drive.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_pop[0] = 0; m_pop[1] = 0; m_ovf = '0; m_rr = 0;
      for (int c = 0; c < 2; c++) begin
        m_data[c] = '0;
        m_data_known[c] = 1'b1;
      end
    end else if (st_vld) begin
      int c = int'(st_core);
      if (m_pop[c] < 256) begin
        m_mem[c*256 + m_pop[c]]   = st_data;
        m_known[c*256 + m_pop[c]] = 1'b1;
        m_pop[c]++;
      end else begin
        m_ovf[c] = 1'b1;
      end
    end else if (e_win >= 0) begin
      int a = e_win*256 + int'(addr_i[e_win*8 +: 8]);
      m_data[e_win]       = m_mem[a];
      m_data_known[e_win] = m_known[a];
      m_rr = (e_win + 1) % 2;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; st_vld = 1'b0; st_core = '0; st_data = '0; rd_i = '0; addr_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    eval(); advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; rd_i = 2'b11;
    eval();
    n_tests++;
    if (stall_o !== 2'b11) begin n_fail++; $display("FAIL reset_stall_11: got %b want %b", stall_o, 2'b11); end
    advance();
    rd_i = 2'b01;
    eval();
    n_tests++;
    if (stall_o !== 2'b01) begin n_fail++; $display("FAIL reset_stall_01: got %b want %b", stall_o, 2'b01); end
    advance();
    rst = 1'b0; rd_i = 2'b00;
    eval();
    n_tests++;
    if (pop_o !== 18'd0 || ovf_o !== 2'b00) begin n_fail++; $display("FAIL reset_counts: pop %h ovf %b want 0", pop_o, ovf_o); end
    n_tests++;
    if (data_o !== 30'd0 || perr_o !== 2'b00) begin n_fail++; $display("FAIL reset_data: data %h perr %b want 0", data_o, perr_o); end
    n_tests++;
    if (stall_o !== 2'b00) begin n_fail++; $display("FAIL reset_idle_stall: got %b want 00", stall_o); end
    advance();
  endtask

  task automatic test_load_fetch();
    idle_inputs();
    st_vld = 1'b1; st_core = 1'b1; st_data = 15'h1234;
    eval(); advance();
    st_data = 15'h0ABC;
    eval(); advance();
    st_vld = 1'b0;
    eval();
    n_tests++;
    if (pop_o[17:9] !== 9'd2 || pop_o[8:0] !== 9'd0) begin n_fail++; $display("FAIL load_populated: got %0d/%0d want 2/0", pop_o[17:9], pop_o[8:0]); end
    advance();
    rd_i = 2'b10; addr_i[15:8] = 8'd1;
    eval();
    n_tests++;
    if (stall_o !== 2'b00 || stall_o !== e_stall) begin n_fail++; $display("FAIL fetch_stall: got %b want 00", stall_o); end
    advance();
    rd_i = 2'b00;
    eval();
    n_tests++;
    if (data_o[29:15] !== 15'h0ABC || m_data[1] !== 15'h0ABC) begin n_fail++; $display("FAIL fetch_data: got %h want 0abc", data_o[29:15]); end
    advance();
  endtask

  task automatic test_overflow();
    logic [14:0] first;
    idle_inputs();
    first = 15'($urandom);
    st_vld = 1'b1; st_core = 1'b0;
    for (int i = 0; i < 257; i++) begin
      st_data = (i == 0) ? first : 15'($urandom);
      eval(); advance();
    end
    st_vld = 1'b0;
    eval();
    n_tests++;
    if (pop_o[8:0] !== 9'd256 || ovf_o !== 2'b01) begin n_fail++; $display("FAIL overflow_flags: pop %0d ovf %b want 256 01", pop_o[8:0], ovf_o); end
    n_tests++;
    if (pop_o[17:9] !== 9'(m_pop[1])) begin n_fail++; $display("FAIL overflow_other_core: got %0d want %0d", pop_o[17:9], m_pop[1]); end
    advance();
    rd_i = 2'b01; addr_i[7:0] = 8'd0;
    eval(); advance();
    rd_i = 2'b00;
    eval();
    n_tests++;
    if (data_o[14:0] !== first) begin n_fail++; $display("FAIL overflow_entry0: got %h want %h", data_o[14:0], first); end
    advance();
  endtask

  task automatic test_contention();
    do_reset();
    rd_i = 2'b11;
    addr_i[7:0]  = 8'($urandom_range(0, 255));
    addr_i[15:8] = 8'($urandom_range(0, 1));
    for (int k = 0; k < 5; k++) begin
      if (k == 4) rd_i = 2'b00;
      eval();
      if (k < 4) begin
        n_tests++;
        if (stall_o !== ((k % 2 == 0) ? 2'b10 : 2'b01) || stall_o !== e_stall) begin
          n_fail++; $display("FAIL contention_stall[%0d]: got %b want %b", k, stall_o, e_stall);
        end
      end
      for (int c = 0; c < 2; c++) begin
        if (k > 0 && m_data_known[c]) begin
          n_tests++;
          if (data_o[c*15 +: 15] !== m_data[c]) begin n_fail++; $display("FAIL contention_data[%0d] core%0d: got %h want %h", k, c, data_o[c*15 +: 15], m_data[c]); end
        end
      end
      advance();
    end
  endtask

  task automatic test_load_priority();
    idle_inputs();
    rd_i = 2'b11; addr_i = 16'h0100;
    st_vld = 1'b1; st_core = 1'b1; st_data = 15'h5A5A;
    eval();
    n_tests++;
    if (stall_o !== 2'b11) begin n_fail++; $display("FAIL prio_load_stall: got %b want 11", stall_o); end
    advance();
    st_vld = 1'b0;
    eval();
    n_tests++;
    if (stall_o !== 2'b10 || stall_o !== e_stall) begin n_fail++; $display("FAIL prio_next_grant: got %b want 10", stall_o); end
    advance();
    rd_i = 2'b00;
    eval();
    n_tests++;
    if (pop_o[17:9] !== 9'(m_pop[1])) begin n_fail++; $display("FAIL prio_populated: got %0d want %0d", pop_o[17:9], m_pop[1]); end
    advance();
  endtask

  task automatic test_reset_mid_fetch();
    logic [14:0] v;
    idle_inputs();
    rd_i = 2'b01; addr_i[7:0] = 8'd5;
    eval(); advance();
    rd_i = 2'b00; rst = 1'b1;
    eval(); advance();
    rst = 1'b0;
    eval();
    n_tests++;
    if (data_o !== 30'd0 || pop_o !== 18'd0 || ovf_o !== 2'b00) begin
      n_fail++; $display("FAIL midreset_clear: data %h pop %h ovf %b want 0", data_o, pop_o, ovf_o);
    end
    advance();
    v = 15'($urandom);
    st_vld = 1'b1; st_core = 1'b0; st_data = v;
    eval(); advance();
    st_vld = 1'b0; rd_i = 2'b01; addr_i[7:0] = 8'd0;
    eval(); advance();
    rd_i = 2'b00;
    eval();
    n_tests++;
    if (data_o[14:0] !== v) begin n_fail++; $display("FAIL midreset_entry0: got %h want %h", data_o[14:0], v); end
    advance();
  endtask

  task automatic test_random();
    logic [1:0] held;
    do_reset();
    held = 2'b00;
    for (int k = 0; k < 300; k++) begin
      st_vld  = ($urandom_range(0, 3) == 0);
      st_core = 1'($urandom_range(0, 1));
      st_data = 15'($urandom);
      for (int c = 0; c < 2; c++) begin
        if (!held[c]) begin
          if (m_pop[c] > 0 && $urandom_range(0, 1) == 1) begin
            rd_i[c] = 1'b1;
            addr_i[c*8 +: 8] = 8'($urandom_range(0, m_pop[c] - 1));
          end else begin
            rd_i[c] = 1'b0;
          end
        end
      end
      eval();
      n_tests++;
      if (stall_o !== e_stall) begin n_fail++; $display("FAIL rand_stall[%0d]: got %b want %b", k, stall_o, e_stall); end
      for (int c = 0; c < 2; c++) begin
        if (m_data_known[c]) begin
          n_tests++;
          if (data_o[c*15 +: 15] !== m_data[c]) begin n_fail++; $display("FAIL rand_data[%0d] core%0d: got %h want %h", k, c, data_o[c*15 +: 15], m_data[c]); end
        end
        n_tests++;
        if (pop_o[c*9 +: 9] !== 9'(m_pop[c])) begin n_fail++; $display("FAIL rand_pop[%0d] core%0d: got %0d want %0d", k, c, pop_o[c*9 +: 9], m_pop[c]); end
      end
      n_tests++;
      if (ovf_o !== m_ovf || perr_o !== 2'b00) begin n_fail++; $display("FAIL rand_flags[%0d]: ovf %b perr %b want %b 00", k, ovf_o, perr_o, m_ovf); end
      held = e_stall;
      advance();
    end
  endtask

  task automatic test_parity();
    logic [1:0] want;
`ifdef NX_INSTR_PARITY_EN
    want = 2'b01;
`else
    want = 2'b00;
`endif
    do_reset();
    st_vld = 1'b1; st_core = 1'b0; st_data = 15'h2AAA;
    eval(); advance();
    st_vld = 1'b0;
`ifdef NX_INSTR_PARITY_EN
    dut.r_mem[0][15] = ~dut.r_mem[0][15];
`endif
    rd_i = 2'b01; addr_i = 16'h0000;
    eval(); advance();
    rd_i = 2'b00;
    eval();
    n_tests++;
    if (data_o[14:0] !== 15'h2AAA) begin n_fail++; $display("FAIL parity_data: got %h want 2aaa", data_o[14:0]); end
    n_tests++;
    if (perr_o !== want) begin n_fail++; $display("FAIL parity_flag: got %b want %b", perr_o, want); end
    advance();
    eval(); advance();
    eval();
    n_tests++;
    if (perr_o !== want) begin n_fail++; $display("FAIL parity_sticky: got %b want %b", perr_o, want); end
    advance();
    rst = 1'b1;
    eval(); advance();
    rst = 1'b0;
    eval();
    n_tests++;
    if (perr_o !== 2'b00) begin n_fail++; $display("FAIL parity_reset: got %b want 00", perr_o); end
    advance();
  endtask

  initial begin
    idle_inputs();
    m_pop[0] = 0; m_pop[1] = 0; m_ovf = '0; m_rr = 0;
    m_data_known[0] = 1'b0; m_data_known[1] = 1'b0;
    test_reset();
    test_load_fetch();
    test_overflow();
    test_contention();
    test_load_priority();
    test_reset_mid_fetch();
    test_random();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
